// File: rtl/rule_cfg_pkg.sv
// rtl/rule_cfg_pkg.sv - shared types and address layout for the rule configuration loader
package rule_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int SPACE_BIT = 16;
  localparam int BEAT_MSB  = 15;
  localparam int BEAT_LSB  = 8;
  localparam int IDX_MSB   = 7;
  localparam int IDX_LSB   = 0;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/rule_cfg_loader.sv
// rtl/rule_cfg_loader.sv - offset register, multi-beat rule staging and commit handshake
module rule_cfg_loader
  import rule_cfg_pkg::*;
#(
  parameter int TYPE_OFFSET_WIDTH = 7,
  parameter int TYPE_NUM          = 4,
  parameter int RULE_NUM          = 8,
  parameter int RULE_WIDTH        = 129,
  parameter int CFG_DW            = 64
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_cfg_valid,
  output logic                                  o_cfg_ready,
  input  logic                                  i_cfg_wr,
  input  logic [31:0]                           i_cfg_addr,
  input  logic [CFG_DW-1:0]                     i_cfg_wdata,
  output logic                                  o_cfg_rvalid,
  output logic [CFG_DW-1:0]                     o_cfg_rdata,
  output logic                                  o_cfg_err,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0] o_type_offset,
  output logic [RULE_NUM-1:0]                   o_rule_wren,
  output logic [RULE_WIDTH-1:0]                 o_rule_wdata,
  input  logic                                  i_rule_ack
);

  localparam int BEATS  = ceil_div(RULE_WIDTH, CFG_DW);
  localparam int FLAT_W = BEATS * CFG_DW;
  localparam int OFS_W  = TYPE_NUM * TYPE_OFFSET_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (OFS_W > CFG_DW) begin : g_bad_ofs
    $error("TYPE_NUM*TYPE_OFFSET_WIDTH exceeds CFG_DW");
  end
  if (RULE_NUM < 1 || RULE_NUM > 256) begin : g_bad_rule_num
    $error("RULE_NUM must be 1..256");
  end
  if (BEATS > 256) begin : g_bad_beats
    $error("RULE_WIDTH needs more than 256 beats");
  end

  state_e              r_state;
  state_e              w_state_nxt;
  logic [FLAT_W-1:0]   r_stage;
  logic [OFS_W-1:0]    r_type_offset;
  logic [7:0]          r_idx;
  logic [7:0]          r_next;
  logic                r_rvalid;
  logic                r_err;
  logic [CFG_DW-1:0]   r_rdata;

  logic                w_accept;
  logic                w_space;
  logic [7:0]          w_beat;
  logic [7:0]          w_idx;
  logic [BEAT_W-1:0]   w_beat_sel;
  logic                w_beat_bad;
  logic                w_idx_bad;
  logic                w_seq_bad;
  logic                w_rule_err;
  logic                w_rule_wr;
  logic                w_rule_store;
  logic                w_read;
  logic                w_last;
  logic [FLAT_W-1:0]   w_stage_rd;
  logic [CFG_DW-1:0]   w_rd_data;
  logic                w_unused;

  assign w_accept   = i_cfg_valid & o_cfg_ready;
  assign w_space    = i_cfg_addr[SPACE_BIT];
  assign w_beat     = i_cfg_addr[BEAT_MSB:BEAT_LSB];
  assign w_idx      = i_cfg_addr[IDX_MSB:IDX_LSB];
  assign w_beat_sel = w_beat[BEAT_W-1:0];
  assign w_beat_bad = {1'b0, w_beat} >= 9'(BEATS);
  assign w_idx_bad  = {1'b0, w_idx} >= 9'(RULE_NUM);
  assign w_last     = {1'b0, w_beat} == 9'(BEATS - 1);
  assign w_unused   = ^{i_cfg_addr[31:SPACE_BIT+1]};

  // Beat 0 is always an acceptable (re)start; any other beat must continue the current fill.
  assign w_seq_bad  = (w_beat != 8'd0) &&
                      ((r_state != FILL) || (w_beat != r_next) || (w_idx != r_idx));
  assign w_rule_err   = w_beat_bad | w_idx_bad | w_seq_bad;
  assign w_rule_wr    = w_accept & i_cfg_wr & w_space;
  assign w_rule_store = w_rule_wr & ~w_rule_err;
  assign w_read       = w_accept & ~i_cfg_wr;

  // Bits above RULE_WIDTH in the last beat always read back as zero.
  assign w_stage_rd = FLAT_W'(r_stage[RULE_WIDTH-1:0]);

  always_comb begin
    w_rd_data = '0;
    if (!w_space) begin
      w_rd_data = CFG_DW'(r_type_offset);
    end else if (!w_beat_bad) begin
      w_rd_data = w_stage_rd[w_beat_sel*CFG_DW +: CFG_DW];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cfg_ready = 1'b1;
    o_rule_wren = '0;
    case (r_state)
      IDLE, FILL: begin
        if (w_rule_wr) begin
          if (w_rule_err)  w_state_nxt = IDLE;
          else if (w_last) w_state_nxt = COMMIT;
          else             w_state_nxt = FILL;
        end
      end
      COMMIT: begin
        o_cfg_ready = 1'b0;
        o_rule_wren = RULE_NUM'(1) << r_idx;
        if (i_rule_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stage       <= '0;
      r_type_offset <= '0;
      r_idx         <= '0;
      r_next        <= '0;
      r_rvalid      <= 1'b0;
      r_err         <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rvalid <= w_read;
      r_err    <= (w_rule_wr & w_rule_err) | (w_read & w_space & w_beat_bad);
      if (w_read) begin
        r_rdata <= w_rd_data;
      end
      if (w_accept && i_cfg_wr && !w_space) begin
        r_type_offset <= i_cfg_wdata[OFS_W-1:0];
      end
      if (w_rule_store) begin
        r_stage[w_beat_sel*CFG_DW +: CFG_DW] <= i_cfg_wdata;
        r_idx  <= w_idx;
        r_next <= w_beat + 8'd1;
      end
    end
  end

  assign o_cfg_rvalid  = r_rvalid;
  assign o_cfg_rdata   = r_rdata;
  assign o_cfg_err     = r_err;
  assign o_type_offset = r_type_offset;
  assign o_rule_wdata  = r_stage[RULE_WIDTH-1:0];

endmodule

// File: tb/tb_rule_cfg_loader.sv
// tb/tb_rule_cfg_loader.sv - directed-vector bench for rule_cfg_loader
module tb_rule_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic         cfg_wr = 1'b0;
  logic [31:0]  cfg_addr = '0;
  logic [63:0]  cfg_wdata = '0;
  logic         cfg_rvalid;
  logic [63:0]  cfg_rdata;
  logic         cfg_err;
  logic [27:0]  type_offset;
  logic [7:0]   rule_wren;
  logic [128:0] rule_wdata;
  logic         rule_ack = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [63:0] BEAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BEAT_B = 64'hBBBB_BBBB_BBBB_BBBB;

  rule_cfg_loader #(
    .TYPE_OFFSET_WIDTH(7), .TYPE_NUM(4), .RULE_NUM(8), .RULE_WIDTH(129), .CFG_DW(64)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_wr(cfg_wr),
    .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
    .o_cfg_rvalid(cfg_rvalid), .o_cfg_rdata(cfg_rdata), .o_cfg_err(cfg_err),
    .o_type_offset(type_offset), .o_rule_wren(rule_wren), .o_rule_wdata(rule_wdata),
    .i_rule_ack(rule_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int beat, input int idx);
    return 32'h0001_0000 | (32'(beat) << 8) | 32'(idx);
  endfunction

  // One request: presented after a falling edge, accepted at the next rising edge, sampled 1 ns later.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] data);
    int waited = 0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_wr    = wr;
    cfg_addr  = addr;
    cfg_wdata = data;
    while (!cfg_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 192'(cfg_ready), 192'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  192'(cfg_ready),   192'd1);
    check("rst_wren",   192'(rule_wren),   192'd0);
    check("rst_offset", 192'(type_offset), 192'd0);
    check("rst_wdata",  192'(rule_wdata),  192'd0);
    check("rst_err",    192'(cfg_err),     192'd0);
    @(negedge clk);
    rst = 1'b0;

    // Offsets: 0x0C1C2814 splits into 7-bit fields 0x14, 0x50, 0x70, 0x60.
    xfer(1'b1, 32'h0000_0000, 64'h0000_0000_0C1C_2814);
    check("ofs0",   192'(type_offset[6:0]),   192'h14);
    check("ofs1",   192'(type_offset[13:7]),  192'h50);
    check("ofs2",   192'(type_offset[20:14]), 192'h70);
    check("ofs3",   192'(type_offset[27:21]), 192'h60);
    check("ofs_err", 192'(cfg_err),           192'd0);
    xfer(1'b0, 32'h0000_0000, '0);
    check("ofs_rvalid", 192'(cfg_rvalid), 192'd1);
    check("ofs_rdata",  192'(cfg_rdata),  192'h0C1C_2814);

    // Rule idx 3, three back-to-back beats, slow ack.
    xfer(1'b1, ra(0, 3), BEAT_A);
    check("r3_b0_wren", 192'(rule_wren), 192'd0);
    xfer(1'b1, ra(1, 3), BEAT_B);
    xfer(1'b1, ra(2, 3), 64'h1);
    check("r3_wren",  192'(rule_wren),  192'h08);
    check("r3_wdata", 192'(rule_wdata), 192'({1'b1, BEAT_B, BEAT_A}));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("r3_hold_ready", 192'(cfg_ready), 192'd0);
      check("r3_hold_wren",  192'(rule_wren), 192'h08);
    end
    @(negedge clk);
    rule_ack = 1'b1;
    @(posedge clk);
    #1;
    check("r3_ack_wren",  192'(rule_wren), 192'd0);
    check("r3_ack_ready", 192'(cfg_ready), 192'd1);
    @(negedge clk);
    rule_ack = 1'b0;
    xfer(1'b0, ra(0, 0), '0);
    check("r3_rd_b0", 192'(cfg_rdata), 192'(BEAT_A));
    check("r3_rd_ok", 192'(cfg_err),   192'd0);

    // Out-of-order beat, then a continuation from IDLE.
    xfer(1'b1, ra(0, 2), 64'h22);
    check("ooo_b0_err", 192'(cfg_err), 192'd0);
    xfer(1'b1, ra(2, 2), 64'h22);
    check("ooo_err",  192'(cfg_err),   192'd1);
    check("ooo_wren", 192'(rule_wren), 192'd0);
    xfer(1'b1, ra(1, 2), 64'h22);
    check("idle_b1_err", 192'(cfg_err), 192'd1);
    @(posedge clk);
    #1;
    check("err_pulse_len", 192'(cfg_err), 192'd0);

    // Range errors.
    xfer(1'b1, ra(0, 9), 64'h9);
    check("idx9_err", 192'(cfg_err), 192'd1);
    xfer(1'b1, ra(3, 0), 64'h3);
    check("beat3_err", 192'(cfg_err), 192'd1);
    xfer(1'b0, ra(3, 0), '0);
    check("rd_b3_err",   192'(cfg_err),   192'd1);
    check("rd_b3_rdata", 192'(cfg_rdata), 192'd0);

    // Restart on beat 0 with a new index; beat 2 data has bits above the rule width set.
    xfer(1'b1, ra(0, 1), 64'h1111);
    xfer(1'b1, ra(0, 5), 64'h5050);
    check("restart_err", 192'(cfg_err), 192'd0);
    xfer(1'b1, ra(1, 5), 64'h5151);
    xfer(1'b1, ra(2, 5), 64'h7);
    check("r5_wren",  192'(rule_wren),  192'h20);
    check("r5_wdata", 192'(rule_wdata), 192'({1'b1, 64'h5151, 64'h5050}));
    @(negedge clk);
    rule_ack = 1'b1;
    @(posedge clk);
    #1;
    check("r5_ack_wren", 192'(rule_wren), 192'd0);
    @(negedge clk);
    rule_ack = 1'b0;
    xfer(1'b0, ra(2, 0), '0);
    check("r5_rd_b2_mask", 192'(cfg_rdata), 192'd1);
    xfer(1'b0, 32'h0000_0000, '0);
    check("ofs_kept", 192'(cfg_rdata), 192'h0C1C_2814);

    // Reset during COMMIT drops wren without a clock edge.
    xfer(1'b1, ra(0, 6), 64'h6);
    xfer(1'b1, ra(1, 6), 64'h6);
    xfer(1'b1, ra(2, 6), 64'h0);
    check("r6_wren", 192'(rule_wren), 192'h40);
    #2 rst = 1'b1;
    #1;
    check("async_wren", 192'(rule_wren), 192'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready",  192'(cfg_ready),   192'd1);
    check("post_rst_offset", 192'(type_offset), 192'd0);
    check("post_rst_wdata",  192'(rule_wdata),  192'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
